// File: rtl/adder_rr_arbiter_if.sv
// Requester/response bundle for the shared-adder arbiter.
// master = requester side, slave = arbiter side.
interface adder_rr_arbiter_if #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W:0]        resp_sum;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_id,
    input  resp_sum
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_id,
    output resp_sum
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one combinational adder among NREQ requesters.
// One transaction in flight: IDLE grant -> EXEC add -> RESP hold until taken.
module adder_rr_arbiter #(
  parameter  int W    = 8,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  adder_rr_arbiter_if.slave bus,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_s,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  cand;
  logic            gnt_any;
  logic            take;
  logic [NREQ-1:0] ready_vec;

  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W:0]      sum_q;
  logic [IDW-1:0]  id_q;
  logic            vld_q;

  function automatic logic [IDW-1:0] wrap_inc(
    input logic [IDW-1:0] id
  );
    if (int'(id) == NREQ - 1) return '0;
    return id + IDW'(1);
  endfunction

  // Walk rr_ptr, rr_ptr+1, ... and keep the first valid hit.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_nx  = state;
    take      = 1'b0;
    ready_vec = '0;
    unique case (state)
      IDLE: begin
        if (gnt_any && !rst) begin
          ready_vec = NREQ'(1) << gnt_id;
          take      = 1'b1;
          state_nx  = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand regs only load on a grant, so the adder inputs stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      sum_q  <= '0;
      id_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (take) begin
        op_a   <= bus.req_a[int'(gnt_id)*W +: W];
        op_b   <= bus.req_b[int'(gnt_id)*W +: W];
        id_q   <= gnt_id;
        rr_ptr <= wrap_inc(gnt_id);
      end
      if (state == EXEC) begin
        sum_q <= add_s;
        vld_q <= 1'b1;
      end
      if (state == RESP && bus.resp_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign add_a          = op_a;
  assign add_b          = op_b;
  assign bus.req_ready  = ready_vec;
  assign bus.resp_valid = vld_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;
  assign busy           = (state != IDLE);

endmodule
